result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter W, default 10, data width of incoming sums.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter ACC_W, default 16, running-total width (ACC_W > W).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous clear of FIFO, total, counters and flags.
REQ-007 SHALL have port in_valid  input  1  upstream result strobe, with no backpressure.
REQ-008 SHALL have port in_data  input  W  upstream result, sampled when in_valid=1.
REQ-009 SHALL have port out_ready  input  1  downstream consumer ready.
REQ-010 SHALL have port out_valid  output  1  FIFO head valid; equals !empty.
REQ-011 SHALL have port out_data  output  W  FIFO head entry.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port acc  output  ACC_W  running total of accepted results.
REQ-014 SHALL have port drop_cnt  output  8  count of results dropped while full, saturating at 255.
REQ-015 SHALL have port acc_sat  output  1  sticky saturation flag (see Configuration).

Function
REQ-016 SHALL run an occupancy state machine with states EMPTY (level=0), PART (0<level<DEPTH) and FULL (level=DEPTH).
REQ-017 SHALL define push as in_valid=1 and pop as out_valid=1 and out_ready=1.
REQ-018 SHALL accept a push when the state is not FULL, or when it is FULL and a pop occurs in the same cycle.
REQ-019 SHALL, on an accepted push, write in_data at the tail; the entry is visible at out_data/out_valid on the next cycle (latency 1).
REQ-020 SHALL, on a pop, advance the head pointer; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 SHALL keep level unchanged on a simultaneous accepted push and pop in PART or FULL.
REQ-022 SHALL, on a simultaneous push and pop in EMPTY, accept the push and ignore the pop, because out_valid=0.
REQ-023 SHALL wrap the head and tail pointers modulo DEPTH.
REQ-024 SHALL, on push in FULL without a pop, discard in_data, leave acc unchanged and increment drop_cnt unless it is already 255.
REQ-025 SHALL, on every accepted push, update acc to acc + zero-extended in_data; when RC_ACC_SAT_EN is undefined the sum SHALL wrap modulo 2^ACC_W.
REQ-026 SHALL give clr priority over push and pop: FIFO goes to EMPTY, acc=0, drop_cnt=0, acc_sat=0; a coincident push SHALL be neither stored nor counted as a drop.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out_data=0, level=0, acc=0, drop_cnt=0, acc_sat=0, pointers=0 and state EMPTY.
REQ-028 SHALL, when reset is asserted mid-operation, discard all FIFO contents immediately; the first push after deassertion SHALL land in entry 0.

Configuration
REQ-029 SHALL use the macro RC_ACC_SAT_EN; when it is defined, an accepted push whose sum exceeds 2^ACC_W-1 SHALL set acc to all-ones and set acc_sat, which stays set until clr or reset.
REQ-030 SHALL, when RC_ACC_SAT_EN is undefined, tie acc_sat to 0 and include no saturation logic.

Verification
REQ-031 SHALL cover: reset, then in_valid=1 with in_data=5 for one cycle and out_ready=0 -> next cycle out_valid=1, out_data=5, level=1, acc=5.
REQ-032 SHALL cover: pushes of 1,2,3,4,5 on consecutive cycles with out_ready=0 -> level=4, drop_cnt=1, acc=10; popping yields 1,2,3,4.
REQ-033 SHALL cover: FULL state with in_valid=1, in_data=9 and out_ready=1 in the same cycle -> level stays 4, drop_cnt unchanged, 9 is popped last.
REQ-034 SHALL cover: out_ready held 1 during 8 consecutive pushes of values 1..8 -> level never exceeds 1 and the pointers wrap past DEPTH without loss.
REQ-035 SHALL cover: acc=65530 followed by a push of 10 -> acc=4 when the macro is undefined; acc=65535 with acc_sat=1 when RC_ACC_SAT_EN is defined.
REQ-036 SHALL cover: clr=1 together with in_valid=1 while level=3 -> next cycle level=0, out_valid=0, acc=0, drop_cnt=0.

Source files
------------

// File: rtl/result_collector.sv
// Result collector: small FIFO for upstream sums with a running total and a drop counter.
// Optional feature macro RC_ACC_SAT_EN: the total saturates at all-ones and raises a sticky acc_sat flag.
module result_collector #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [ACC_W-1:0]         acc,
  output logic [7:0]               drop_cnt,
  output logic                     acc_sat
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [LW-1:0]    level_nxt;
  logic             push;
  logic             pop;
  logic             accept;
  logic             drop;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_set;

  assign push      = in_valid;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[head] : '0;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    accept    = 1'b0;
    drop      = 1'b0;
    level_nxt = level;
    state_nxt = state;
    if (clr) begin
      level_nxt = '0;
      state_nxt = EMPTY;
    end else begin
      accept = push && ((state != FULL) || pop);
      drop   = push && (state == FULL) && !pop;
      if (accept && !pop) begin
        level_nxt = level + LW'(1);
      end else if (!accept && pop) begin
        level_nxt = level - LW'(1);
      end
      if (level_nxt == '0) begin
        state_nxt = EMPTY;
      end else if (level_nxt == LW'(DEPTH)) begin
        state_nxt = FULL;
      end else begin
        state_nxt = PART;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (accept) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail] <= in_data;
    end
  end

`ifdef RC_ACC_SAT_EN
  logic [ACC_W:0] sum;

  always_comb begin
    sum     = {1'b0, acc} + (ACC_W + 1)'(in_data);
    sat_set = sum[ACC_W];
    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sat <= 1'b0;
    end else if (clr) begin
      acc_sat <= 1'b0;
    end else if (accept && sat_set) begin
      acc_sat <= 1'b1;
    end
  end
`else
  always_comb begin
    sat_set = 1'b0;
    acc_nxt = acc + ACC_W'(in_data);
  end

  assign acc_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
    end
  end

  // Drops are only counted when the push is refused; the counter sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: data scoreboard plus an occupancy/total/drop model.
// Compile with +define+RC_ACC_SAT_EN to check the saturating build.
module tb_result_collector;

  localparam int W     = 10;
  localparam int DEPTH = 4;
  localparam int ACC_W = 16;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [2:0]       level;
  logic [ACC_W-1:0] acc;
  logic [7:0]       drop_cnt;
  logic             acc_sat;

  int               vectors;
  int               errors;
  logic [W-1:0]     sb[$];
  int               exp_level;
  logic [ACC_W-1:0] exp_acc;
  int               exp_drop;
  logic             exp_sat;
  logic [W-1:0]     last_pop;

  result_collector #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .acc       (acc),
    .drop_cnt  (drop_cnt),
    .acc_sat   (acc_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every real pop is compared against the oldest accepted push.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_data: popped %0d, required no pop (scoreboard empty)", out_data);
      end else begin
        logic [W-1:0] exp_d;
        exp_d = sb.pop_front();
        if (out_data !== exp_d) begin
          errors++;
          $display("[TB] FAIL pop_data: got %0d, expected %0d", out_data, exp_d);
        end
        last_pop = out_data;
      end
    end
  end

  task automatic model_reset();
    exp_level = 0;
    exp_acc   = '0;
    exp_drop  = 0;
    exp_sat   = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, update the model, and return just after the rising edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    logic [ACC_W:0] s;
    logic           p;
    logic           a;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    p = r && (exp_level != 0);
    if (c) begin
      model_reset();
    end else begin
      a = v && ((exp_level < DEPTH) || p);
      if (a) begin
        sb.push_back(d);
        s = {1'b0, exp_acc} + {7'b0, d};
`ifdef RC_ACC_SAT_EN
        if (s[ACC_W]) begin
          exp_acc = '1;
          exp_sat = 1'b1;
        end else begin
          exp_acc = s[ACC_W-1:0];
        end
`else
        exp_acc = s[ACC_W-1:0];
`endif
      end
      if (v && !a && exp_drop != 255) exp_drop++;
      exp_level = exp_level + (a ? 1 : 0) - (p ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 10'd3, 1'b1, 1'b0);
    model_reset();
    vectors++;
    if ({out_valid, out_data, level, acc, drop_cnt, acc_sat} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%0b data=%0d level=%0d acc=%0d drop=%0d sat=%0b, expected all zero",
               out_valid, out_data, level, acc, drop_cnt, acc_sat);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_single_push();
    drive(1'b1, 10'd5, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 10'd5 || level !== 3'd1 || acc !== 16'd5) begin
      errors++;
      $display("[TB] FAIL single_push: valid=%0b data=%0d level=%0d acc=%0d, expected 1/5/1/5",
               out_valid, out_data, level, acc);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL single_pop: valid=%0b level=%0d, expected 0/0", out_valid, level);
    end
  endtask

  task automatic test_fill_drop();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    vectors++;
    if (level !== 3'd4 || drop_cnt !== 8'd1 || acc !== 16'd10) begin
      errors++;
      $display("[TB] FAIL fill_drop: level=%0d drop=%0d acc=%0d, expected 4/1/10", level, drop_cnt, acc);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 10'd1) begin
      errors++;
      $display("[TB] FAIL hold_stable: data=%0d, expected 1", out_data);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (level !== 3'd0 || last_pop !== 10'd4 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: level=%0d last=%0d left=%0d, expected 0/4/0", level, last_pop, sb.size());
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    drive(1'b1, 10'd9, 1'b1, 1'b0);
    vectors++;
    if (level !== 3'd4 || drop_cnt !== 8'd0 || acc !== 16'd19) begin
      errors++;
      $display("[TB] FAIL full_push_pop: level=%0d drop=%0d acc=%0d, expected 4/0/19", level, drop_cnt, acc);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (last_pop !== 10'd9 || level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL full_last: last=%0d level=%0d, expected 9/0", last_pop, level);
    end
  endtask

  task automatic test_back_to_back();
    int max_level;
    max_level = 0;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      if (int'(level) > max_level) max_level = int'(level);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (max_level > 1 || last_pop !== 10'd8 || level !== 3'd0 || acc !== 16'd36) begin
      errors++;
      $display("[TB] FAIL back_to_back: max_level=%0d last=%0d level=%0d acc=%0d, expected <=1/8/0/36",
               max_level, last_pop, level, acc);
    end
  endtask

  task automatic test_acc_wrap();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) drive(1'b1, 10'd1023, 1'b1, 1'b0);
    drive(1'b1, 10'd58, 1'b1, 1'b0);
    vectors++;
    if (acc !== 16'd65530) begin
      errors++;
      $display("[TB] FAIL acc_preload: acc=%0d, expected 65530", acc);
    end
    drive(1'b1, 10'd10, 1'b1, 1'b0);
    vectors++;
`ifdef RC_ACC_SAT_EN
    if (acc !== 16'd65535 || acc_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL acc_sat: acc=%0d sat=%0b, expected 65535/1", acc, acc_sat);
    end
    drive(1'b1, 10'd1, 1'b1, 1'b0);
    vectors++;
    if (acc !== 16'd65535 || acc_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL acc_sat_hold: acc=%0d sat=%0b, expected 65535/1", acc, acc_sat);
    end
`else
    if (acc !== 16'd4 || acc_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL acc_wrap: acc=%0d sat=%0b, expected 4/0", acc, acc_sat);
    end
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(10 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (level !== 3'd3 || drop_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL clr_setup: level=%0d drop=%0d, expected 3/1", level, drop_cnt);
    end
    drive(1'b1, 10'd77, 1'b1, 1'b1);
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0 || acc !== 16'd0 || drop_cnt !== 8'd0 || acc_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr: level=%0d valid=%0b acc=%0d drop=%0d sat=%0b, expected all zero",
               level, out_valid, acc, drop_cnt, acc_sat);
    end
  endtask

  task automatic test_drop_saturate();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4 + 300; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    vectors++;
    if (drop_cnt !== 8'd255 || level !== 3'd4) begin
      errors++;
      $display("[TB] FAIL drop_sat: drop=%0d level=%0d, expected 255/4", drop_cnt, level);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 3; i++) drive(1'b1, W'(20 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0 || acc !== 16'd0 || out_data !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: level=%0d valid=%0b acc=%0d data=%0d, expected zeros",
               level, out_valid, acc, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 10'd7, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 10'd7 || level !== 3'd1 || acc !== 16'd7) begin
      errors++;
      $display("[TB] FAIL post_reset_push: data=%0d level=%0d acc=%0d, expected 7/1/7", out_data, level, acc);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      vectors++;
      if (level !== 3'(exp_level) || acc !== exp_acc || drop_cnt !== 8'(exp_drop) ||
          out_valid !== (exp_level != 0) || acc_sat !== exp_sat) begin
        errors++;
        $display("[TB] FAIL random[%0d]: level=%0d/%0d acc=%0d/%0d drop=%0d/%0d valid=%0b sat=%0b/%0b (got/expected)",
                 i, level, exp_level, acc, exp_acc, drop_cnt, exp_drop, out_valid, acc_sat, exp_sat);
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (sb.size() != 0 || level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL random_drain: left=%0d level=%0d, expected 0/0", sb.size(), level);
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    last_pop  = '0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_push();
    test_fill_drop();
    test_full_push_pop();
    test_back_to_back();
    test_acc_wrap();
    test_clear();
    test_drop_saturate();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
